lcd_driver: RTL and testbench
=============================

# lcd_driver

Write-cycle generator for an HD44780-compatible character LCD in 8-bit parallel mode. It sits between the display controller FSM and the LCD pins. It latches one command or data byte per request, then drives RS and the data bus with correct setup time. It generates a fixed-width E (enable) pulse, holds the bus afterwards, and enforces a post-write recovery interval before it accepts the next byte.

## Interface
- `SETUP_CYCLES`, default 3: clocks from RS/data valid to E rising (60 ns at 50 MHz; the LCD needs at least 40 ns).
- `EN_CYCLES`, default 25: E high width in clocks (500 ns at 50 MHz).
- `HOLD_CYCLES`, default 2: clocks RS/data stay stable after E falls.
- `WAIT_CYCLES`, default 2000: recovery clocks after hold before the next request is accepted (40 µs at 50 MHz).
- All parameters are ≥1 and ≤65535; the internal timer is 16 bits.

Ports:
- `clk`, input, 1: single system clock, 50 MHz nominal; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `lcd_data_in`, input, 8: byte to write (command or character code).
- `lcd_send`, input, 1: write request, sampled only in IDLE.
- `rs_select`, input, 1: 0 selects command register, 1 selects data register.
- `lcd_rs`, output, 1: LCD RS pin (registered).
- `lcd_en`, output, 1: LCD E pin (registered).
- `lcd_data_bus`, output, 8: LCD DB7..DB0 (registered).
- `lcd_busy`, output, 1: high while a transaction is in progress (SETUP through WAIT).

## Operation
- FSM states:
  - IDLE: waits for a request.
  - SETUP: E low, bus valid, counts `SETUP_CYCLES`.
  - PULSE: E high, counts `EN_CYCLES`.
  - HOLD: E low, bus unchanged, counts `HOLD_CYCLES`.
  - WAIT: counts `WAIT_CYCLES`, then returns to IDLE.
- In IDLE, `lcd_send`=1 at a rising edge does the following on that edge:
  - captures `lcd_data_in` into `lcd_data_bus` and `rs_select` into `lcd_rs`;
  - sets `lcd_busy`=1;
  - enters SETUP with the timer cleared.
- Each timed state lasts exactly its parameter count of clocks. On the final count the FSM advances and clears the timer.
- `lcd_en` is 1 only in PULSE.
- `lcd_rs` and `lcd_data_bus` change only at capture. They keep the last written value through HOLD, WAIT and IDLE until the next capture.
- `lcd_send`, `lcd_data_in` and `rs_select` are ignored outside IDLE. A request made while busy is dropped, not queued.
- `lcd_send` is level-sampled. If it is still 1 when the FSM is back in IDLE, a new transaction starts on that edge. A one-clock strobe yields exactly one write.
- The LCD is write-only. RW is tied low externally and the driver never reads the busy flag.
- Power-on initialisation sequencing (0x38, 0x0C, 0x01, ...) belongs to the upstream controller, not this block.

## Timing
- Reset (`rst`=0, asynchronous): `lcd_en`=0, `lcd_rs`=0, `lcd_data_bus`=8'h00, `lcd_busy`=0, FSM=IDLE, timer=0. Deasserting reset then requires one clock edge before a request is accepted.
- Reset during any state forces E low at once, with no completion of the pulse.
- Let edge k capture the request:
  - `lcd_rs`/`lcd_data_bus` are valid after edge k.
  - `lcd_en` rises after edge k+`SETUP_CYCLES` and falls after edge k+`SETUP_CYCLES`+`EN_CYCLES`.
  - HOLD ends at k+S+E+H.
  - `lcd_busy` falls after edge k+S+E+H+W.
  - The earliest next capture is at that same edge.
- With default parameters:
  - E rises 60 ns after capture.
  - E is high for exactly 500 ns.
  - The full transaction is (3+25+2+2000)×20 ns = 40.6 µs.
- Glitch-free outputs: every output comes straight from a flip-flop, with no combinational path from input to output.

## Test plan
- Reset: hold `rst`=0 for 4 clocks with random inputs → `lcd_en`=0, `lcd_rs`=0, `lcd_data_bus`=0x00 and `lcd_busy`=0 throughout; then release.
- Command write: `lcd_data_in`=0x38, `rs_select`=0, one-clock `lcd_send` → `lcd_rs`=0 and bus=0x38 after the capture edge; E rises 60 ns later and is high exactly 500 ns; `lcd_busy` is high 40.6 µs; the bus holds 0x38 afterwards.
- Sequential writes 100 µs apart: 0x01 with rs=0, then 0x54 with rs=1 → each produces exactly one 500 ns E pulse with matching RS/bus; the bus reads 0x54 with `lcd_rs`=1 at the end.
- Request while busy: send 0x38, then 10 µs later pulse `lcd_send` with 0xFF → no second E pulse; the bus stays 0x38.
- Held request: keep `lcd_send`=1 for 100 µs → E pulses start every 40.6 µs (3 pulses), each 500 ns wide.
- Reset mid-pulse: assert `rst`=0 200 ns into E high → `lcd_en` drops asynchronously; all outputs return to reset values; after release the next request behaves normally.

Source files
------------

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_driver
//  Description : Write-cycle generator for an HD44780-compatible character
//                LCD in 8-bit parallel mode. Latches one command/data byte per
//                request, applies RS/DB setup time, produces a fixed-width E
//                pulse, holds the bus, then enforces a recovery interval
//                before the next request is accepted.
//  Ports       : clk          - system clock, rising edge
//                rst          - asynchronous active-low reset
//                lcd_data_in  - byte to write
//                lcd_send     - write request (level, sampled when idle)
//                rs_select    - 0 = command register, 1 = data register
//                lcd_rs       - LCD RS pin (registered)
//                lcd_en       - LCD E pin (registered)
//                lcd_data_bus - LCD DB7..DB0 (registered)
//                lcd_busy     - transaction in progress (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_driver #(
    parameter int SETUP_CYCLES = 3,
    parameter int EN_CYCLES    = 25,
    parameter int HOLD_CYCLES  = 2,
    parameter int WAIT_CYCLES  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data_in,
    input  logic       lcd_send,
    input  logic       rs_select,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data_bus,
    output logic       lcd_busy
);

    // Terminal timer values: a state lasting N clocks advances when the
    // timer, cleared on entry, has reached N-1.
    localparam logic [15:0] C_SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] C_EN_LAST    = 16'(EN_CYCLES - 1);
    localparam logic [15:0] C_HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] C_WAIT_LAST  = 16'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic        rs_q;
    logic        en_q;
    logic [7:0]  data_q;
    logic        busy_q;

    logic [15:0] timer_last_d;
    logic        timer_done_d;

    always_comb begin
        timer_last_d = 16'd0;
        case (state_q)
            S_SETUP: timer_last_d = C_SETUP_LAST;
            S_PULSE: timer_last_d = C_EN_LAST;
            S_HOLD:  timer_last_d = C_HOLD_LAST;
            S_WAIT:  timer_last_d = C_WAIT_LAST;
            default: timer_last_d = 16'd0;
        endcase
        timer_done_d = (timer_q == timer_last_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= 16'd0;
                    if (lcd_send) begin
                        data_q  <= lcd_data_in;
                        rs_q    <= rs_select;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (timer_done_d) begin
                        timer_q <= 16'd0;
                        en_q    <= 1'b1;
                        state_q <= S_PULSE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_PULSE: begin
                    if (timer_done_d) begin
                        timer_q <= 16'd0;
                        en_q    <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (timer_done_d) begin
                        timer_q <= 16'd0;
                        state_q <= S_WAIT;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (timer_done_d) begin
                        timer_q <= 16'd0;
                        // The edge that ends recovery is also the first edge
                        // at which a new request may be captured, so a held
                        // request restarts without an idle gap.
                        if (lcd_send) begin
                            data_q  <= lcd_data_in;
                            rs_q    <= rs_select;
                            state_q <= S_SETUP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    timer_q <= 16'd0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lcd_rs       = rs_q;
    assign lcd_en       = en_q;
    assign lcd_data_bus = data_q;
    assign lcd_busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_driver
//  Description : Self-checking bench for lcd_driver. A reference model
//                tracks transactions as capture cycle numbers; expected
//                writes are queued and popped by a monitor on each E rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_driver;

    localparam int S = 3;
    localparam int E = 25;
    localparam int H = 2;
    localparam int W = 2000;
    localparam int T = S + E + H + W;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic       lcd_send = 1'b0;
    logic       rs_select = 1'b0;
    logic       lcd_rs;
    logic       lcd_en;
    logic [7:0] lcd_data_bus;
    logic       lcd_busy;

    lcd_driver #(
        .SETUP_CYCLES(S), .EN_CYCLES(E), .HOLD_CYCLES(H), .WAIT_CYCLES(W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_data_in  (lcd_data_in),
        .lcd_send     (lcd_send),
        .rs_select    (rs_select),
        .lcd_rs       (lcd_rs),
        .lcd_en       (lcd_en),
        .lcd_data_bus (lcd_data_bus),
        .lcd_busy     (lcd_busy)
    );

    always #10 clk = ~clk;   // 50 MHz

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         k;
    } wr_t;

    wr_t        exp_q[$];
    int         cyc     = 0;   // number of rising edges seen
    int         free_at = 0;   // first edge at which a new capture is allowed
    int         last_k  = 0;
    bit         have_k  = 0;
    logic       m_rs    = 1'b0;
    logic [7:0] m_data  = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            free_at <= 0;
            have_k  <= 0;
            m_rs    <= 1'b0;
            m_data  <= 8'h00;
            exp_q.delete();
        end else if (lcd_send && (cyc + 1 >= free_at)) begin
            exp_q.push_back('{rs: rs_select, data: lcd_data_in, k: cyc + 1});
            last_k  <= cyc + 1;
            have_k  <= 1;
            free_at <= cyc + 1 + T;
            m_rs    <= rs_select;
            m_data  <= lcd_data_in;
        end
    end

    // ---------------- monitor ----------------
    logic        prev_en = 1'b0;
    int          rise_cyc = 0;
    int          n_rises = 0;
    logic [10:0] prev_dut = '1;
    logic [10:0] prev_mdl = '1;

    always @(negedge clk) begin
        logic [10:0] dutv;
        logic [10:0] mdlv;
        logic        en_m;
        logic        busy_m;
        wr_t         w;
        en_m   = rst && have_k && (cyc >= last_k + S) && (cyc < last_k + S + E);
        busy_m = rst && (cyc < free_at);
        dutv   = {lcd_en, lcd_rs, lcd_data_bus, lcd_busy};
        mdlv   = rst ? {en_m, m_rs, m_data, busy_m} : 11'd0;
        if (dutv !== prev_dut || mdlv !== prev_mdl)
            check("outputs", {21'd0, dutv}, {21'd0, mdlv});
        prev_dut = dutv;
        prev_mdl = mdlv;

        if (lcd_en && !prev_en) begin
            n_rises++;
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("pulse_rs_data_rise", {lcd_rs, lcd_data_bus, cyc[22:0]},
                      {w.rs, w.data, 23'(w.k + S)});
            end
        end
        if (!lcd_en && prev_en && rst)
            check("pulse_width", 32'(cyc - rise_cyc), 32'(E));
        prev_en = lcd_en;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] d, input logic rs, input int len);
        lcd_data_in = d;
        rs_select   = rs;
        lcd_send    = 1'b1;
        tick(len);
        lcd_send    = 1'b0;
        lcd_data_in = 8'($urandom);
        rs_select   = 1'($urandom);
    endtask

    initial begin
        int n0;
        int guard;
        // Reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lcd_data_in = 8'($urandom);
            rs_select   = 1'($urandom);
            lcd_send    = 1'($urandom);
            @(negedge clk);
            check("reset_outputs", {21'd0, lcd_en, lcd_rs, lcd_data_bus, lcd_busy}, 32'd0);
        end
        lcd_send = 1'b0;
        rst = 1'b1;
        tick(3);

        // Command write
        strobe(8'h38, 1'b0, 1);
        tick(T + 20);
        check("cmd_bus_hold", {23'd0, lcd_rs, lcd_data_bus}, {23'd0, 1'b0, 8'h38});

        // Sequential writes 100 us apart
        strobe(8'h01, 1'b0, 1);
        tick(5000);
        strobe(8'h54, 1'b1, 1);
        tick(5000);
        check("seq_final", {23'd0, lcd_rs, lcd_data_bus}, {23'd0, 1'b1, 8'h54});

        // Request while busy is dropped
        n0 = n_rises;
        strobe(8'h38, 1'b0, 1);
        tick(500);
        strobe(8'hFF, 1'b1, 1);
        tick(T);
        check("busy_drop_bus", {24'd0, lcd_data_bus}, 32'h38);
        check("busy_drop_pulses", 32'(n_rises - n0), 32'd1);

        // Held request for 100 us
        n0 = n_rises;
        lcd_data_in = 8'($urandom);
        rs_select   = 1'($urandom);
        lcd_send    = 1'b1;
        tick(5000);
        lcd_send    = 1'b0;
        tick(T + 20);
        check("held_pulses", 32'(n_rises - n0), 32'd3);

        // Reset 200 ns into E high
        strobe(8'($urandom), 1'($urandom), 1);
        guard = 0;
        while (!lcd_en && guard < 50) begin
            tick(1);
            guard++;
        end
        check("en_rise_timeout", 32'(guard < 50), 32'd1);
        tick(10);
        #3 rst = 1'b0;
        #1 check("async_reset", {21'd0, lcd_en, lcd_rs, lcd_data_bus, lcd_busy}, 32'd0);
        tick(3);
        rst = 1'b1;
        tick(3);
        strobe(8'($urandom), 1'($urandom), 1);
        tick(T + 20);

        // Random requests at random spacing and strobe lengths
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'($urandom_range(0, 3000)); j++) begin
                lcd_data_in = 8'($urandom);
                rs_select   = 1'($urandom);
                tick(1);
            end
            strobe(8'($urandom), 1'($urandom), int'($urandom_range(1, 3)));
        end
        tick(T + 20);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
